// File: rtl/arb_pkg.sv
// Shared encodings for the request arbiter: priority mode values and FSM states.
// Pure declarations; no logic, no latency, no flow control.
package arb_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational winner search: fixed (highest index first) or round-robin starting below i_last.
// Zero latency; no backpressure, the caller decides when the result is taken.
module rr_priority_pick
   import arb_pkg::*;
#(
   parameter  int N     = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_last,
   input  logic             i_mode,
   output logic             o_any,
   output logic [IDX_W-1:0] o_idx,
   output logic [N-1:0]     o_onehot
);

   logic [IDX_W-1:0] w_base;
   int               w_j;

   // Fixed priority is round-robin with the pointer pinned at 0: order N-1 .. 0.
   assign w_base = (i_mode == MODE_FIXED) ? '0 : i_last;

   always_comb begin
      o_any    = 1'b0;
      o_idx    = '0;
      o_onehot = '0;
      w_j      = 0;
      for (int i = 1; i <= N; i++) begin
         w_j = (int'(w_base) + N - i) % N;
         if (!o_any && i_req[w_j]) begin
            o_any         = 1'b1;
            o_idx         = IDX_W'(w_j);
            o_onehot[w_j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/req_priority_arbiter.sv
// N-way registered arbiter, fixed or round-robin, grant held until ack/withdraw/timeout.
// One cycle from request to grant; back-to-back grants on ack with no bubble.
module req_priority_arbiter
   import arb_pkg::*;
#(
   parameter  int N       = 4,
   parameter  int TIMEOUT = 0,
   parameter  int CNT_W   = 8,
   localparam int IDX_W   = $clog2(N)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_mode,
   input  logic [N-1:0]     i_req,
   input  logic             i_ack,
   input  logic             i_cnt_clr,
   output logic             o_grant_valid,
   output logic [IDX_W-1:0] o_grant_idx,
   output logic [N-1:0]     o_grant_onehot,
   output logic             o_timeout,
   output logic [CNT_W-1:0] o_grant_cnt
);

   localparam int AGE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t           r_state;
   logic             r_vld;
   logic [IDX_W-1:0] r_idx;
   logic [N-1:0]     r_onehot;
   logic             r_timeout;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_last;
   logic [AGE_W-1:0] r_age;

   state_t           w_state_nxt;
   logic             w_vld_nxt;
   logic [IDX_W-1:0] w_idx_nxt;
   logic [N-1:0]     w_onehot_nxt;
   logic [AGE_W-1:0] w_age_nxt;
   logic [IDX_W-1:0] w_last_nxt;

   logic             w_in_grant;
   logic             w_to_hit;
   logic             w_ev_ack;
   logic             w_ev_wd;
   logic             w_ev_to;
   logic             w_repick;
   logic             w_pick_any;
   logic [IDX_W-1:0] w_pick_idx;
   logic [N-1:0]     w_pick_onehot;

   assign w_in_grant = (r_state == ST_GRANT);
   assign w_to_hit   = (TIMEOUT != 0) && (r_age == AGE_W'(TIMEOUT - 1));
   assign w_ev_ack   = w_in_grant && i_ack;
   assign w_ev_wd    = w_in_grant && !i_ack && !i_req[r_idx];
   assign w_ev_to    = w_in_grant && !i_ack && i_req[r_idx] && w_to_hit;
   assign w_repick   = !w_in_grant || w_ev_ack || w_ev_wd || w_ev_to;

   // The pointer moves on ack or forced release, and the re-pick at that same edge already sees it.
   assign w_last_nxt = (w_ev_ack || w_ev_to) ? r_idx : r_last;

   rr_priority_pick #(
      .N (N)
   ) u_pick (
      .i_req    (i_req),
      .i_last   (w_last_nxt),
      .i_mode   (i_mode),
      .o_any    (w_pick_any),
      .o_idx    (w_pick_idx),
      .o_onehot (w_pick_onehot)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_vld_nxt    = r_vld;
      w_idx_nxt    = r_idx;
      w_onehot_nxt = r_onehot;
      w_age_nxt    = r_age;
      if (w_repick) begin
         w_age_nxt = '0;
         if (w_pick_any) begin
            w_state_nxt  = ST_GRANT;
            w_vld_nxt    = 1'b1;
            w_idx_nxt    = w_pick_idx;
            w_onehot_nxt = w_pick_onehot;
         end else begin
            w_state_nxt  = ST_IDLE;
            w_vld_nxt    = 1'b0;
            w_onehot_nxt = '0;
         end
      end else if (TIMEOUT != 0) begin
         w_age_nxt = r_age + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_vld     <= 1'b0;
         r_idx     <= '0;
         r_onehot  <= '0;
         r_timeout <= 1'b0;
         r_cnt     <= '0;
         r_last    <= '0;
         r_age     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_vld     <= w_vld_nxt;
         r_idx     <= w_idx_nxt;
         r_onehot  <= w_onehot_nxt;
         r_timeout <= w_ev_to;
         r_last    <= w_last_nxt;
         r_age     <= w_age_nxt;
         if (i_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_ev_ack && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_grant_valid  = r_vld;
   assign o_grant_idx    = r_idx;
   assign o_grant_onehot = r_onehot;
   assign o_timeout      = r_timeout;
   assign o_grant_cnt    = r_cnt;

endmodule

// File: tb/tb_req_priority_arbiter.sv
// Bench for req_priority_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_req_priority_arbiter;

   localparam int N       = 4;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 4;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             mode;
   logic [N-1:0]     req;
   logic             ack;
   logic             cnt_clr;
   logic             grant_valid;
   logic [1:0]       grant_idx;
   logic [N-1:0]     grant_onehot;
   logic             timeout;
   logic [CNT_W-1:0] grant_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   int m_vld, m_idx, m_last, m_held, m_cnt, m_to;

   always #5 clk = ~clk;

   req_priority_arbiter #(
      .N       (N),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_mode         (mode),
      .i_req          (req),
      .i_ack          (ack),
      .i_cnt_clr      (cnt_clr),
      .o_grant_valid  (grant_valid),
      .o_grant_idx    (grant_idx),
      .o_grant_onehot (grant_onehot),
      .o_timeout      (timeout),
      .o_grant_cnt    (grant_cnt)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Walk the search order the rules define: start just below the pointer (0 in fixed mode) and wrap.
   function automatic int pick(input logic [N-1:0] r, input int last, input logic md);
      int start;
      int c;
      start = md ? last : 0;
      for (int k = 1; k <= N; k++) begin
         c = (start - k + N) % N;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   function automatic int hsb(input logic [N-1:0] r);
      for (int k = N - 1; k >= 0; k--) if (r[k]) return k;
      return -1;
   endfunction

   always @(posedge clk) begin : model
      int nxt;
      bit repick;
      if (!rst_n) begin
         m_vld = 0; m_idx = 0; m_last = 0; m_held = 0; m_cnt = 0; m_to = 0;
      end else begin
         repick = 1'b0;
         m_to   = 0;
         if (m_vld == 0) begin
            repick = 1'b1;
         end else if (ack) begin
            m_last = m_idx;
            m_cnt  = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            repick = 1'b1;
         end else if (!req[m_idx]) begin
            repick = 1'b1;
         end else if (m_held == TIMEOUT) begin
            m_last = m_idx;
            m_to   = 1;
            repick = 1'b1;
         end else begin
            m_held++;
         end
         if (cnt_clr) m_cnt = 0;
         if (repick) begin
            nxt = pick(req, m_last, mode);
            if (nxt >= 0) begin
               m_vld = 1; m_idx = nxt; m_held = 1;
            end else begin
               m_vld = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", int'(grant_valid), m_vld);
         if (m_vld != 0) chk("idx", int'(grant_idx), m_idx);
         chk("onehot", int'(grant_onehot), (m_vld != 0) ? (1 << m_idx) : 0);
         chk("timeout", int'(timeout), m_to);
         chk("cnt", int'(grant_cnt), m_cnt);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_rr[5];
      logic [N-1:0] v;
      exp_rr = '{3, 2, 1, 0, 3};
      rst_n = 1'b0; mode = 1'b0; req = 4'b1111; ack = 1'b0; cnt_clr = 1'b0;
      cyc(); cyc();
      chk("rst_valid", int'(grant_valid), 0);
      chk("rst_idx", int'(grant_idx), 0);
      chk("rst_onehot", int'(grant_onehot), 0);
      chk("rst_cnt", int'(grant_cnt), 0);
      chk("rst_timeout", int'(timeout), 0);
      chk_en = 1'b1;
      rst_n = 1'b1;
      cyc();
      chk("first_idx", int'(grant_idx), 3);
      chk("first_onehot", int'(grant_onehot), 8);

      // Fixed priority sweep
      req = '0; cyc();
      for (int i = 0; i < 16; i++) begin
         v = 4'(i);
         req = v; ack = 1'b0;
         cyc();
         if (i == 0) chk("fix_none_valid", int'(grant_valid), 0);
         else        chk("fix_hsb", int'(grant_idx), hsb(v));
         if (i == 6) chk("fix_0110", int'(grant_idx), 2);
         if (i == 3) chk("fix_0011", int'(grant_idx), 1);
         if (i == 9) chk("fix_1001", int'(grant_idx), 3);
         ack = 1'b1; req = '0;
         cyc();
         ack = 1'b0;
      end

      // Round robin, ack every cycle from a fresh pointer
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      mode = 1'b1; req = 4'b1111;
      cyc();
      ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("rr_seq", int'(grant_idx), exp_rr[i]);
         chk("rr_valid", int'(grant_valid), 1);
         cyc();
      end
      ack = 1'b0;
      chk("rr_cnt", int'(grant_cnt), 5);

      // Withdraw keeps the pointer
      req = '0; cyc();
      req = 4'b0100; cyc();
      chk("wd_grant", int'(grant_idx), 2);
      req = '0; cyc();
      chk("wd_valid", int'(grant_valid), 0);
      chk("wd_cnt", int'(grant_cnt), 5);
      req = 4'b0110; cyc();
      chk("wd_regrant", int'(grant_idx), 2);
      req = '0; cyc();

      // Timeout
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      mode = 1'b1; req = 4'b1010;
      for (int i = 0; i < TIMEOUT; i++) begin
         cyc();
         chk("to_hold_idx", int'(grant_idx), 3);
         chk("to_hold_pulse", int'(timeout), 0);
      end
      cyc();
      chk("to_pulse", int'(timeout), 1);
      chk("to_next_idx", int'(grant_idx), 1);
      chk("to_cnt", int'(grant_cnt), 0);
      cyc();
      chk("to_pulse_end", int'(timeout), 0);

      // Counter saturation and clear-with-ack
      req = '0; cyc();
      cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
      mode = 1'b0; req = 4'b1111; cyc();
      ack = 1'b1;
      repeat (17) cyc();
      chk("cnt_sat", int'(grant_cnt), 15);
      cnt_clr = 1'b1; cyc();
      chk("cnt_clr_ack", int'(grant_cnt), 0);
      cnt_clr = 1'b0; ack = 1'b0;

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         ack = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 9) == 0) mode = ~mode;
         cnt_clr = ($urandom_range(0, 49) == 0);
         cyc();
      end
      rst_n = 1'b1; ack = 1'b0; cnt_clr = 1'b0;
      cyc();
      chk_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
